dead_time_gen: RTL



---
 rtl/dead_time_gen_pkg.sv | 14 +
 rtl/dead_time_gen_cell.sv | 91 +++++++++
 rtl/dead_time_gen.sv | 59 +++++
 3 files changed

// File: rtl/dead_time_gen_pkg.sv
// Shared sizes and channel FSM encoding for the gate dead-time generator.
package dead_time_gen_pkg;

    localparam int DEF_N_CELLS  = 5;
    localparam int DEF_DT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DEAD = 2'd3
    } dt_state_t;

endpackage

// File: rtl/dead_time_gen_cell.sv
// One switch-pair channel: target-following FSM, dead-time counter and
// registered complementary gate drive.
module dead_time_cell
    import dead_time_gen_pkg::*;
#(
    parameter int DT_WIDTH = DEF_DT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable_eff,
    input  logic [DT_WIDTH-1:0] dt_cycles,
    input  logic                cmd,
    output logic                gate_h,
    output logic                gate_l
);

    dt_state_t           state;
    dt_state_t           state_nxt;
    logic [DT_WIDTH-1:0] count;
    logic [DT_WIDTH-1:0] count_nxt;
    logic [DT_WIDTH-1:0] dt_load;
    logic                target;
    logic                target_nxt;
    logic                h_nxt;
    logic                l_nxt;

    // Counter runs dt-1 .. 0, so the side asserts exactly dt edges after entry.
    assign dt_load = (dt_cycles == '0) ? '0 : dt_cycles - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            target <= 1'b0;
            gate_h <= 1'b0;
            gate_l <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            target <= target_nxt;
            gate_h <= h_nxt;
            gate_l <= l_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        target_nxt = target;
        if (!enable_eff) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt  = DEAD;
                    count_nxt  = dt_load;
                    target_nxt = cmd;
                end
                HIGH, LOW: begin
                    if (cmd != (state == HIGH)) begin
                        target_nxt = cmd;
                        if (dt_cycles == '0) begin
                            state_nxt = cmd ? HIGH : LOW;
                        end else begin
                            state_nxt = DEAD;
                            count_nxt = dt_load;
                        end
                    end
                end
                DEAD: begin
                    if (cmd != target) begin
                        target_nxt = cmd;
                        count_nxt  = dt_load;
                    end else if (count == '0) begin
                        state_nxt = target ? HIGH : LOW;
                    end else begin
                        count_nxt = count - 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        h_nxt = (state_nxt == HIGH);
        l_nxt = (state_nxt == LOW);
    end

endmodule

// File: rtl/dead_time_gen.sv
// Per-phase dead-time generator; DT_SHOOT_THROUGH_CHECK_EN adds the sticky
// shoot-through-request fault on dpwm_s/dpwm_sb agreement.
module dead_time_gen
    import dead_time_gen_pkg::*;
#(
    parameter int N_CELLS  = DEF_N_CELLS,
    parameter int DT_WIDTH = DEF_DT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [DT_WIDTH-1:0] dt_cycles,
    input  logic [N_CELLS-1:0]  dpwm_s,
    input  logic [N_CELLS-1:0]  dpwm_sb,
    output logic [N_CELLS-1:0]  gate_h,
    output logic [N_CELLS-1:0]  gate_l,
    output logic                fault
);

    logic enable_eff;

`ifdef DT_SHOOT_THROUGH_CHECK_EN
    logic shoot;

    assign shoot = enable & (|(dpwm_s ~^ dpwm_sb));

    always_ff @(posedge clk) begin
        if (rst) begin
            fault <= 1'b0;
        end else if (shoot) begin
            fault <= 1'b1;
        end
    end

    // The live request also gates, so the cells drop to 00 on the setting edge.
    assign enable_eff = enable & ~fault & ~shoot;
`else
    logic unused_sb;

    assign unused_sb  = ^dpwm_sb;
    assign fault      = 1'b0;
    assign enable_eff = enable;
`endif

    for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
        dead_time_cell #(
            .DT_WIDTH(DT_WIDTH)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .enable_eff(enable_eff),
            .dt_cycles (dt_cycles),
            .cmd       (dpwm_s[i]),
            .gate_h    (gate_h[i]),
            .gate_l    (gate_l[i])
        );
    end

endmodule
